// File: rtl/pc_sequencer.sv
// Program counter sequencer: selects the next fetch address from sequential,
// jump, call, branch or return-stack sources and flags wrong-path squashes.
module pc_sequencer #(
    parameter int unsigned     PC_W      = 8,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_target,
    input  logic            call_en,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            ret_en,
    input  logic            halt,
    output logic [PC_W-1:0] pc_out,
    output logic            instr_valid,
    output logic            flush,
    output logic            ras_overflow,
    output logic            ras_underflow,
    output logic            halted
);

    localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   ras_top;
    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];
    logic [CNT_W-1:0]  ras_cnt;
    logic [CNT_W-1:0]  ras_cnt_nxt;
    logic              ras_empty;
    logic              ras_full;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic              unf_set;

    assign pc_inc    = pc_out + PC_W'(1);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == FULL_CNT);
    assign ras_top   = ras_mem[PTR_W'(ras_cnt - CNT_W'(1))];

    // Next-state, next-PC and stack control; stall leaves every default in place
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_out;
        push        = 1'b0;
        pop         = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;
        ras_cnt_nxt = ras_cnt;

        if (!stall) begin
            unique case (state)
                ST_START: state_nxt = ST_RUN;
                ST_RUN, ST_FLUSH: begin
                    if (halt) begin
                        state_nxt = ST_HALT;
                    end else if (ret_en) begin
                        if (ras_empty) begin
                            unf_set   = 1'b1;
                            pc_nxt    = pc_inc;
                            state_nxt = ST_RUN;
                        end else begin
                            pop       = 1'b1;
                            pc_nxt    = ras_top;
                            state_nxt = ST_FLUSH;
                        end
                    end else if (call_en) begin
                        if (ras_full) begin
                            ovf_set = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                        pc_nxt    = jump_target;
                        state_nxt = ST_FLUSH;
                    end else if (jump_en) begin
                        pc_nxt    = jump_target;
                        state_nxt = ST_FLUSH;
                    end else if (branch_en) begin
                        pc_nxt    = pc_inc + branch_offset;
                        state_nxt = ST_FLUSH;
                    end else begin
                        pc_nxt    = pc_inc;
                        state_nxt = ST_RUN;
                    end
                end
                ST_HALT: state_nxt = ST_HALT;
                default: state_nxt = ST_START;
            endcase
        end

        if (push) begin
            ras_cnt_nxt = ras_cnt + CNT_W'(1);
        end else if (pop) begin
            ras_cnt_nxt = ras_cnt - CNT_W'(1);
        end
    end

    // State, PC, stack depth and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_START;
            pc_out        <= RESET_PC;
            ras_cnt       <= '0;
            instr_valid   <= 1'b0;
            flush         <= 1'b0;
            halted        <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc_out        <= pc_nxt;
            ras_cnt       <= ras_cnt_nxt;
            instr_valid   <= (state_nxt == ST_RUN) || (state_nxt == ST_FLUSH);
            flush         <= (state_nxt == ST_FLUSH);
            halted        <= (state_nxt == ST_HALT);
            ras_overflow  <= ras_overflow | ovf_set;
            ras_underflow <= ras_underflow | unf_set;
        end
    end

    // Return-address storage; contents need no reset since depth is tracked separately
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[PTR_W'(ras_cnt)] <= pc_inc;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 8-bit program counter and consumes the redirect targets produced by the jump/branch address logic. Each cycle it selects the next PC from sequential increment, pseudo-direct jump target, PC-relative branch, or a return-stack pop. It presents the fetch address with a valid qualifier to instruction memory. After any taken redirect it asserts a one-cycle flush to squash the wrong-path instruction.

Parameters:
PC_W, 8, program counter width; all address arithmetic is modulo 2^PC_W
RAS_DEPTH, 4, return-address stack entries (power of two, at least 2)
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  freeze: PC, state and stack hold; outputs hold
jump_en  in  1  unconditional jump to jump_target
jump_target  in  PC_W  precomputed pseudo-direct target {pc[7:5], imm[4:0]}
call_en  in  1  jump to jump_target and push return address
branch_en  in  1  branch taken (condition already resolved)
branch_offset  in  PC_W  signed two's-complement word offset
ret_en  in  1  pop return stack into PC
halt  in  1  enter HALT state
pc_out  out  PC_W  current fetch address
instr_valid  out  1  pc_out is a valid fetch this cycle
flush  out  1  squash the instruction fetched in the previous cycle
ras_overflow  out  1  sticky: push attempted with stack full
ras_underflow  out  1  sticky: pop attempted with stack empty
halted  out  1  in HALT state

Behaviour:
- Reset (async, rst_n low): pc_out=RESET_PC, state=START, instr_valid=0, flush=0, halted=0, both sticky flags=0, stack empty (count=0). Stack contents are don't-care.
- States:
  - START: one cycle after reset release, instr_valid=0, PC held. Always goes to RUN.
  - RUN: instr_valid=1. Computes next PC.
  - FLUSH: one cycle, flush=1, instr_valid=1 (fetching the redirected PC). Next PC selection applies as in RUN, so back-to-back redirects are legal.
  - HALT: instr_valid=0, halted=1, PC frozen. Exits only by reset.
- Next-PC priority in RUN/FLUSH, highest first:
  1. halt: go to HALT, PC unchanged.
  2. ret_en: PC ← top of stack, pop.
  3. call_en: push (pc_out+1), then PC ← jump_target.
  4. jump_en: PC ← jump_target.
  5. branch_en: PC ← pc_out+1+branch_offset.
  6. Otherwise: PC ← pc_out+1.
  - Lower-priority requests in the same cycle are ignored.
- Any taken redirect (items 2–5) moves the state to FLUSH for the next cycle. A sequential step goes to RUN.
- Wrap-around: all sums truncate to PC_W bits. 8'hFF+1 = 8'h00. Branch from 8'h02 with offset 8'hFC (−4) gives 8'hFF.
- Stack full on call: push is dropped, ras_overflow sets, jump still taken.
- Stack empty on ret: ras_underflow sets, PC ← pc_out+1, no flush, state goes to RUN.
- Sticky flags clear only on reset.
- stall=1 has precedence over everything except reset. A pending FLUSH state is held, not consumed, while stalled.
- All outputs are registered. A redirect issued in cycle N appears on pc_out in cycle N+1, with flush=1 in N+1.
- Reset asserted mid-operation (including during FLUSH or HALT) returns immediately to the reset values.

Test Plan:
- Reset then 3 free-running cycles: START (pc 00, valid 0), then pc 00, 01, 02 with valid=1 and flush=0.
- jump_en with jump_target=8'h1A at pc 05: next cycle pc=1A, flush=1; the cycle after, pc=1B, flush=0.
- call_en at pc 10 to target 40, then ret_en at pc 42: pc=40 then 41, 42, then pc=11 with flush=1. Flags remain 0.
- Five calls with RAS_DEPTH=4: fifth call sets ras_overflow but still jumps. Five rets: first four return in LIFO order, fifth sets ras_underflow and increments PC.
- pc at FF with no redirect → 00. Branch at 02 with offset FC → FF. stall held 3 cycles during FLUSH: pc and flush=1 stay frozen, FLUSH completes after stall drops.
- halt asserted together with jump_en at pc 07: pc stays 07, halted=1, valid=0. Async rst_n pulse mid-HALT returns to START with pc=00.
